// File: rtl/route_compute_array.sv
// route_compute_array
//   Pipelined XY (dimension-order, X first) route-computation stage for the
//   mesh router. Each of NUM_CH channels independently accepts one header
//   flit, decodes its source/destination against this router's address and
//   presents a registered copy of the flit with its output-port code.
//   Flits whose source equals their destination are consumed, never shown
//   at the output, and flagged with a one-cycle err_pulse.
//
//   Optional feature macro: ROUTE_ERRCNT_EN
//     When defined, adds err_cnt, a per-channel 8-bit saturating count of
//     dropped malformed flits.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cur_addr   this router's {x, y}
//   in_valid   per-channel header flit valid
//   in_ready   per-channel accept (combinational from out_ready)
//   in_data    flattened flits, channel c at [c*DATA_W +: DATA_W]
//   out_valid  per-channel routed flit valid
//   out_ready  per-channel downstream accept
//   out_data   registered flit copy per channel
//   out_port   2 bits per channel: 01 = X, 10 = Y, 11 = local, 00 = none
//   out_neg    per channel: 1 = toward decreasing coordinate
//   err_pulse  per channel: one cycle after a malformed flit is dropped
//   err_cnt    (ROUTE_ERRCNT_EN only) 8 bits per channel drop count

module route_compute_array #(
  parameter int NUM_CH  = 3,
  parameter int COORD_W = 1,
  parameter int DATA_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*COORD_W-1:0]     cur_addr,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [2*NUM_CH-1:0]      out_port,
  output logic [NUM_CH-1:0]        out_neg,
  output logic [NUM_CH-1:0]        err_pulse
`ifdef ROUTE_ERRCNT_EN
  ,
  output logic [NUM_CH*8-1:0]      err_cnt
`endif
);

  localparam int AW = 2 * COORD_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  // Dimension-order route for one destination: returns {port[1:0], neg}.
  // X is resolved first; local only when both axes already match.
  function automatic logic [2:0] route_f(input logic [AW-1:0] dst,
                                         input logic [AW-1:0] cur);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    dx = dst[AW-1:COORD_W];
    dy = dst[COORD_W-1:0];
    cx = cur[AW-1:COORD_W];
    cy = cur[COORD_W-1:0];
    if (dx != cx) begin
      route_f = {2'b01, (dx < cx)};
    end else if (dy != cy) begin
      route_f = {2'b10, (dy < cy)};
    end else begin
      route_f = {2'b11, 1'b0};
    end
  endfunction

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c = c + 1) begin : g_ch
      ch_state_e         state_r;
      ch_state_e         state_s;
      logic [DATA_W-1:0] flit_s;
      logic [AW-1:0]     src_s;
      logic [AW-1:0]     dst_s;
      logic              malformed_s;
      logic              in_ready_s;
      logic              accept_s;
      logic              load_s;
      logic              drop_s;
      logic [2:0]        route_s;
      logic [DATA_W-1:0] data_r;
      logic [1:0]        port_r;
      logic              neg_r;
      logic              err_r;

      assign flit_s      = in_data[c*DATA_W +: DATA_W];
      assign src_s       = flit_s[DATA_W-1 -: AW];
      assign dst_s       = flit_s[DATA_W-1-AW -: AW];
      assign malformed_s = (src_s == dst_s);
      // A full slot can still accept when its flit retires on the same edge.
      assign in_ready_s  = (state_r == ST_EMPTY) | out_ready[c];
      assign accept_s    = in_valid[c] & in_ready_s;
      assign load_s      = accept_s & ~malformed_s;
      assign drop_s      = accept_s & malformed_s;
      assign route_s     = route_f(dst_s, cur_addr);

      // Next-state logic for the one-entry output slot.
      always_comb begin
        state_s = state_r;
        case (state_r)
          ST_EMPTY: begin
            if (load_s) begin
              state_s = ST_FULL;
            end else begin
              state_s = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (load_s) begin
              state_s = ST_FULL;
            end else if (out_ready[c]) begin
              state_s = ST_EMPTY;
            end else begin
              state_s = ST_FULL;
            end
          end
          default: state_s = ST_EMPTY;
        endcase
      end

      // Slot state register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_r <= ST_EMPTY;
        end else begin
          state_r <= state_s;
        end
      end

      // Flit copy and route registers; held (not cleared) when the slot empties.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_r <= {DATA_W{1'b0}};
          port_r <= 2'b00;
          neg_r  <= 1'b0;
        end else if (load_s) begin
          data_r <= flit_s;
          port_r <= route_s[2:1];
          neg_r  <= route_s[0];
        end
      end

      // Registered drop indicator, high for the cycle after the drop edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          err_r <= 1'b0;
        end else begin
          err_r <= drop_s;
        end
      end

`ifdef ROUTE_ERRCNT_EN
      logic [7:0] cnt_r;

      // Saturating drop counter, updated on the same edge that raises err_pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= 8'd0;
        end else if (drop_s && (cnt_r != 8'd255)) begin
          cnt_r <= cnt_r + 8'd1;
        end
      end

      assign err_cnt[c*8 +: 8] = cnt_r;
`endif

      assign in_ready[c]                 = in_ready_s;
      assign out_valid[c]                = (state_r == ST_FULL);
      assign out_data[c*DATA_W +: DATA_W] = data_r;
      assign out_port[2*c +: 2]          = port_r;
      assign out_neg[c]                  = neg_r;
      assign err_pulse[c]                = err_r;
    end
  endgenerate

endmodule

// File: tb/tb_route_compute_array.sv
// tb_route_compute_array
//   Directed-vector bench for route_compute_array. One instance uses the
//   default parameters (3 channels, 1-bit coordinates); a second, single
//   channel instance uses 3-bit coordinates. Expected values are hand-derived.

module tb_route_compute_array;

  logic         clk;
  logic         rst_n;

  // default-parameter instance
  logic [1:0]   cur_addr;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [119:0] in_data;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [119:0] out_data;
  logic [5:0]   out_port;
  logic [2:0]   out_neg;
  logic [2:0]   err_pulse;
`ifdef ROUTE_ERRCNT_EN
  logic [23:0]  err_cnt;
`endif

  // COORD_W = 3 instance
  logic [5:0]   c3_cur_addr;
  logic [0:0]   c3_in_valid;
  logic [0:0]   c3_in_ready;
  logic [39:0]  c3_in_data;
  logic [0:0]   c3_out_valid;
  logic [0:0]   c3_out_ready;
  logic [39:0]  c3_out_data;
  logic [1:0]   c3_out_port;
  logic [0:0]   c3_out_neg;
  logic [0:0]   c3_err_pulse;
`ifdef ROUTE_ERRCNT_EN
  logic [7:0]   c3_err_cnt;
`endif

  int n_vec;
  int n_err;

  logic [39:0] fa;
  logic [39:0] fb;

  route_compute_array #(.NUM_CH(3), .COORD_W(1), .DATA_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .cur_addr(cur_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_port(out_port), .out_neg(out_neg), .err_pulse(err_pulse)
`ifdef ROUTE_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  route_compute_array #(.NUM_CH(1), .COORD_W(3), .DATA_W(40)) dut_c3 (
    .clk(clk), .rst_n(rst_n), .cur_addr(c3_cur_addr),
    .in_valid(c3_in_valid), .in_ready(c3_in_ready), .in_data(c3_in_data),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready), .out_data(c3_out_data),
    .out_port(c3_out_port), .out_neg(c3_out_neg), .err_pulse(c3_err_pulse)
`ifdef ROUTE_ERRCNT_EN
    , .err_cnt(c3_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] mk1(input logic [1:0] s, input logic [1:0] d,
                                      input logic [35:0] p);
    return {s, d, p};
  endfunction

  function automatic logic [39:0] mk3(input logic [5:0] s, input logic [5:0] d,
                                      input logic [27:0] p);
    return {s, d, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if (out_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid: got %b want 000", out_valid); end
    n_vec++;
    if (out_port !== 6'b000000) begin n_err++; $display("FAIL reset_port: got %b want 000000", out_port); end
    n_vec++;
    if (out_data !== 120'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_vec++;
    if ({out_neg, err_pulse} !== 6'b000000) begin n_err++; $display("FAIL reset_neg_err: got %b want 000000", {out_neg, err_pulse}); end
    n_vec++;
    if (in_ready !== 3'b111) begin n_err++; $display("FAIL reset_in_ready: got %b want 111", in_ready); end
    n_vec++;
    if (c3_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_c3_valid: got %b want 0", c3_out_valid); end
  endtask

  task automatic test_x_route();
    cur_addr = 2'b00;
    fa = mk1(2'b01, 2'b10, 36'h123456789);
    in_data[39:0] = fa;
    in_valid = 3'b001;
    tick();
    in_valid = 3'b000;
    n_vec++;
    if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL x_valid: got %b want 1", out_valid[0]); end
    n_vec++;
    if (out_port[1:0] !== 2'b01) begin n_err++; $display("FAIL x_port: got %b want 01", out_port[1:0]); end
    n_vec++;
    if (out_neg[0] !== 1'b0) begin n_err++; $display("FAIL x_neg: got %b want 0", out_neg[0]); end
    n_vec++;
    if (out_data[39:0] !== fa) begin n_err++; $display("FAIL x_data: got %h want %h", out_data[39:0], fa); end
    tick();
    n_vec++;
    if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL x_retire: got %b want 0", out_valid[0]); end
    n_vec++;
    if (out_data[39:0] !== fa) begin n_err++; $display("FAIL x_hold_empty: got %h want %h", out_data[39:0], fa); end
  endtask

  task automatic test_back_to_back();
    cur_addr = 2'b11;
    fa = mk1(2'b00, 2'b11, 36'hAAAA00001);
    fb = mk1(2'b00, 2'b10, 36'h555500002);
    in_data[119:80] = fa;
    in_valid = 3'b100;
    tick();
    n_vec++;
    if ({out_valid[2], out_port[5:4], out_neg[2]} !== 4'b1110) begin
      n_err++; $display("FAIL b2b_local: got %b want 1110", {out_valid[2], out_port[5:4], out_neg[2]});
    end
    in_data[119:80] = fb;
    tick();
    in_valid = 3'b000;
    n_vec++;
    if ({out_valid[2], out_port[5:4], out_neg[2]} !== 4'b1101) begin
      n_err++; $display("FAIL b2b_y_neg: got %b want 1101", {out_valid[2], out_port[5:4], out_neg[2]});
    end
    n_vec++;
    if (out_data[119:80] !== fb) begin n_err++; $display("FAIL b2b_data: got %h want %h", out_data[119:80], fb); end
    tick();
    n_vec++;
    if (out_valid[2] !== 1'b0) begin n_err++; $display("FAIL b2b_retire: got %b want 0", out_valid[2]); end
  endtask

  task automatic test_malformed();
    cur_addr = 2'b00;
    in_data[79:40] = mk1(2'b10, 2'b10, 36'h0000000BB);
    in_valid = 3'b010;
    tick();
    in_valid = 3'b000;
    n_vec++;
    if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL mal_valid: got %b want 0", out_valid[1]); end
    n_vec++;
    if (err_pulse !== 3'b010) begin n_err++; $display("FAIL mal_pulse: got %b want 010", err_pulse); end
    tick();
    n_vec++;
    if (err_pulse !== 3'b000) begin n_err++; $display("FAIL mal_pulse_end: got %b want 000", err_pulse); end
    // good flit then malformed flit while full: good one retires, slot empties
    fa = mk1(2'b00, 2'b01, 36'h0000000CC);
    in_data[79:40] = fa;
    in_valid = 3'b010;
    tick();
    n_vec++;
    if ({out_valid[1], out_port[3:2], out_neg[1]} !== 4'b1100) begin
      n_err++; $display("FAIL mal_pre_good: got %b want 1100", {out_valid[1], out_port[3:2], out_neg[1]});
    end
    in_data[79:40] = mk1(2'b01, 2'b01, 36'h0000000DD);
    tick();
    in_valid = 3'b000;
    n_vec++;
    if ({out_valid[1], err_pulse[1]} !== 2'b01) begin
      n_err++; $display("FAIL mal_in_full: got %b want 01", {out_valid[1], err_pulse[1]});
    end
    n_vec++;
    if (out_data[79:40] !== fa) begin n_err++; $display("FAIL mal_data_kept: got %h want %h", out_data[79:40], fa); end
`ifdef ROUTE_ERRCNT_EN
    in_data[79:40] = mk1(2'b10, 2'b10, 36'h0000000EE);
    in_valid = 3'b010;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 3'b000;
    tick();
    n_vec++;
    if (err_cnt[15:8] !== 8'd255) begin n_err++; $display("FAIL errcnt_sat: got %0d want 255", err_cnt[15:8]); end
    n_vec++;
    if (err_cnt[7:0] !== 8'd0) begin n_err++; $display("FAIL errcnt_ch0: got %0d want 0", err_cnt[7:0]); end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    cur_addr = 2'b00;
    fa = mk1(2'b00, 2'b10, 36'h00000A0A0);
    fb = mk1(2'b11, 2'b00, 36'h00000B0B0);
    in_data[39:0] = fa;
    in_valid = 3'b001;
    tick();
    out_ready = 3'b110;
    in_data[39:0] = fb;
    #1;
    n_vec++;
    if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready[0]); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({out_valid[0], out_port[1:0], out_neg[0], out_data[39:0]} !== {1'b1, 2'b01, 1'b0, fa}) begin
        n_err++; $display("FAIL bp_hold cycle %0d: got %b/%b/%b/%h want 1/01/0/%h",
                          i, out_valid[0], out_port[1:0], out_neg[0], out_data[39:0], fa);
      end
    end
    out_ready = 3'b111;
    #1;
    n_vec++;
    if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready[0]); end
    tick();
    in_valid = 3'b000;
    n_vec++;
    if ({out_valid[0], out_port[1:0], out_data[39:0]} !== {1'b1, 2'b11, fb}) begin
      n_err++; $display("FAIL bp_reload: got %b/%b/%h want 1/11/%h", out_valid[0], out_port[1:0], out_data[39:0], fb);
    end
    tick();
  endtask

  task automatic test_coord3();
    c3_cur_addr = {3'd3, 3'd3};
    c3_in_data = mk3({3'd0, 3'd0}, {3'd5, 3'd1}, 28'h1111111);
    c3_in_valid = 1'b1;
    tick();
    n_vec++;
    if ({c3_out_valid, c3_out_port, c3_out_neg} !== 4'b1010) begin
      n_err++; $display("FAIL c3_x: got %b want 1010", {c3_out_valid, c3_out_port, c3_out_neg});
    end
    c3_in_data = mk3({3'd0, 3'd0}, {3'd3, 3'd1}, 28'h2222222);
    tick();
    c3_in_valid = 1'b0;
    n_vec++;
    if ({c3_out_valid, c3_out_port, c3_out_neg} !== 4'b1101) begin
      n_err++; $display("FAIL c3_y_neg: got %b want 1101", {c3_out_valid, c3_out_port, c3_out_neg});
    end
    tick();
  endtask

  task automatic test_async_reset();
    cur_addr = 2'b00;
    in_data = {mk1(2'b00, 2'b11, 36'h3), mk1(2'b00, 2'b01, 36'h2), mk1(2'b00, 2'b10, 36'h1)};
    in_valid = 3'b111;
    c3_in_data = mk3(6'd0, 6'd9, 28'h5);
    c3_in_valid = 1'b1;
    tick();
    out_ready = 3'b000;
    c3_out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 3'b111) begin n_err++; $display("FAIL ar_loaded: got %b want 111", out_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_neg, err_pulse, out_port} !== 15'd0) begin
      n_err++; $display("FAIL ar_ctrl: got %b want 0", {out_valid, out_neg, err_pulse, out_port});
    end
    n_vec++;
    if (out_data !== 120'd0) begin n_err++; $display("FAIL ar_data: got %h want 0", out_data); end
    n_vec++;
    if ({c3_out_valid, c3_out_data} !== 41'd0) begin n_err++; $display("FAIL ar_c3: got %h want 0", {c3_out_valid, c3_out_data}); end
    in_valid = 3'b000;
    c3_in_valid = 1'b0;
    out_ready = 3'b111;
    c3_out_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    fa = mk1(2'b01, 2'b10, 36'hFEEDF00D1);
    in_data[39:0] = fa;
    in_valid = 3'b001;
    tick();
    in_valid = 3'b000;
    n_vec++;
    if ({out_valid[0], out_port[1:0], out_neg[0], out_data[39:0]} !== {1'b1, 2'b01, 1'b0, fa}) begin
      n_err++; $display("FAIL ar_first_flit: got %b/%b/%b/%h want 1/01/0/%h",
                        out_valid[0], out_port[1:0], out_neg[0], out_data[39:0], fa);
    end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    cur_addr = 2'b00;
    in_valid = 3'b000;
    in_data = 120'd0;
    out_ready = 3'b111;
    c3_cur_addr = 6'd0;
    c3_in_valid = 1'b0;
    c3_in_data = 40'd0;
    c3_out_ready = 1'b1;
    #12;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_x_route();
    test_back_to_back();
    test_malformed();
    test_backpressure();
    test_coord3();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/route_compute_array.md
# route_compute_array

Parametrised, pipelined XY route-computation stage for the mesh router. Accepts up to NUM_CH header flits in parallel, one per input FIFO channel, and decodes source/destination coordinates against the router's own location. Produces a registered output-port code per channel behind a valid/ready handshake. Drops malformed packets (source == destination) and flags them. Sits between the input FIFOs and the output-path muxes/arbiter.

## Interface
- NUM_CH, 3: number of independent input channels (1..8); channel 0 = X, 1 = Y, 2 = local by convention.
- COORD_W, 1: bits per coordinate axis; address = {x, y}, 2*COORD_W bits.
- DATA_W, 40: flit width; header fields at MSBs: src = [DATA_W-1 -: 2*COORD_W], dst = next 2*COORD_W bits below.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- cur_addr  in  2*COORD_W  this router's {x, y}, quasi-static.
- in_valid  in  NUM_CH  header flit valid per channel.
- in_ready  out  NUM_CH  stage can accept on channel.
- in_data  in  NUM_CH*DATA_W  flattened flits, channel c at [c*DATA_W +: DATA_W].
- out_valid  out  NUM_CH  routed flit valid.
- out_ready  in  NUM_CH  downstream accepts.
- out_data  out  NUM_CH*DATA_W  registered flit copy.
- out_port  out  2*NUM_CH  per channel: 01 = X, 10 = Y, 11 = local, 00 = none.
- out_neg  out  NUM_CH  1 = travel toward decreasing coordinate on selected axis.
- err_pulse  out  NUM_CH  one-cycle pulse when a malformed flit is dropped.

## Operation
- Channels fully independent; identical per-channel logic.
- Decode: sx, sy, dx, dy from header; cx, cy from cur_addr.
- Malformed: {sx,sy} == {dx,dy}. Flit consumed on handshake, never presented at output; err_pulse[c] = 1 for the following cycle.
- Dimension-order routing, X first:
  - dx != cx: port 01, out_neg = (dx < cx).
  - else dy != cy: port 10, out_neg = (dy < cy).
  - else: port 11, out_neg = 0.
- Comparisons unsigned, COORD_W bits; no wrap-around (mesh, not torus).
- Per-channel state: EMPTY (out_valid = 0) / FULL (out_valid = 1).
  - EMPTY, in_valid & good flit → FULL, load data/port/neg.
  - FULL, out_ready & no new good flit → EMPTY.
  - FULL, out_ready & in_valid & good flit → stay FULL, reload (back-to-back).
  - FULL, !out_ready → hold all outputs stable.
- in_ready[c] = !out_valid[c] | out_ready[c] (combinational from out_ready).
- Malformed flit in FULL with out_ready: current flit retires, stage goes EMPTY, err_pulse fires.
- out_data/out_port/out_neg are don't-care-free: hold last loaded value when EMPTY.

## Timing
- Latency 1 cycle: flit accepted at edge N is valid after edge N.
- Throughput 1 flit/cycle/channel with out_ready held high.
- Reset (async assert, sync-safe release): out_valid = 0, out_port = 00, out_neg = 0, out_data = 0, err_pulse = 0; asserting rst_n low mid-transfer discards held flits immediately.
- cur_addr change takes effect on the next accepted flit; held flits keep old route.
- err_pulse is registered: high exactly one cycle after the dropping edge.

## Configuration
- ROUTE_ERRCNT_EN defined: adds output err_cnt (NUM_CH*8 bits), per-channel 8-bit saturating count of dropped malformed flits; reset 0; saturates at 255; increments coincident with err_pulse.
- Undefined: no err_cnt port, no counter logic; err_pulse behaviour unchanged.

## Test plan
- Defaults, cur_addr = 2'b00, ch0 flit src = 01, dst = 10, out_ready = 1 → next cycle out_valid[0] = 1, out_port[1:0] = 01, out_neg[0] = 0.
- cur_addr = 2'b11, ch2 src = 00, dst = 11 → port 11; dst = 10 → port 10, out_neg = 1 (y: 0 < 1).
- Ch1 src = dst = 10 → out_valid[1] stays 0, err_pulse[1] one cycle; with ROUTE_ERRCNT_EN, 300 such flits → err_cnt ch1 = 255.
- out_ready[0] = 0 with out_valid[0] = 1, in_valid[0] = 1 → in_ready[0] = 0, outputs unchanged for 5 cycles; release → flit retires, next loads same edge.
- COORD_W = 3, cur = {3,3}, dst = {5,1} → port 01, out_neg 0; dst = {3,1} → port 10, out_neg 1.
- Assert rst_n low mid-stream on all channels → all outputs 0 asynchronously; release, first flit routes correctly.
